// File: rtl/layer_scanner.sv
// One-hot LED layer driver: blanking gap before each layer, programmable hold,
// single-layer or free-running auto-scan with graceful stop and frame pulse.
module layer_scanner #(
  parameter int unsigned NUM_LAYERS   = 8,
  parameter int unsigned HOLD_CYCLES  = 375000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned LW           = $clog2(NUM_LAYERS),
  parameter int unsigned CW           = $clog2(((HOLD_CYCLES > BLANK_CYCLES) ?
                                                HOLD_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  auto_mode,
  input  logic                  stop,
  input  logic [LW-1:0]         layer_i,
  output logic                  done,
  output logic                  blank,
  output logic [NUM_LAYERS-1:0] layer_out,
  output logic [LW-1:0]         layer_idx,
  output logic                  frame_done,
  output logic                  start_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam state_t        LOAD_STATE = (BLANK_CYCLES == 0) ? S_ACTIVE : S_BLANK;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [LW-1:0]           r_idx;
  logic                    r_auto;
  logic                    r_stop_pend;
  logic                    r_done;
  logic                    r_blank;
  logic [NUM_LAYERS-1:0]   r_layer_out;
  logic                    r_frame_done;
  logic                    r_start_err;

  state_t                  w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [LW-1:0]           w_idx_nxt;
  logic                    w_auto_nxt;
  logic                    w_stop_nxt;
  logic                    w_start_bad;
  logic                    w_in_range;
  logic                    w_done_nxt;
  logic                    w_blank_nxt;
  logic [NUM_LAYERS-1:0]   w_layer_nxt;
  logic                    w_frame_nxt;

  // Only a non-power-of-two layer count can receive an out-of-range index.
  if (NUM_LAYERS < (2 ** LW)) begin : g_range
    assign w_in_range = (layer_i < LW'(NUM_LAYERS));
  end else begin : g_full
    assign w_in_range = 1'b1;
  end

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_auto       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_done       <= 1'b1;
      r_blank      <= 1'b0;
      r_layer_out  <= '0;
      r_frame_done <= 1'b0;
      r_start_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_auto       <= w_auto_nxt;
      r_stop_pend  <= w_stop_nxt;
      r_done       <= w_done_nxt;
      r_blank      <= w_blank_nxt;
      r_layer_out  <= w_layer_nxt;
      r_frame_done <= w_frame_nxt;
      r_start_err  <= w_start_bad;
    end
  end

  // Next-state logic; the shared counter restarts from zero on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_auto_nxt  = r_auto;
    w_stop_nxt  = r_stop_pend;
    w_start_bad = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_stop_nxt = 1'b0;
        if (start) begin
          if (w_in_range) begin
            w_idx_nxt   = layer_i;
            w_auto_nxt  = auto_mode;
            w_state_nxt = LOAD_STATE;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      S_BLANK: begin
        w_stop_nxt = r_stop_pend | stop;
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ACTIVE: begin
        w_stop_nxt = r_stop_pend | stop;
        if (r_cnt == HOLD_LAST) begin
          if (!r_auto || r_stop_pend) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
          end else begin
            w_idx_nxt   = (r_idx == LAST_LAYER) ? '0 : r_idx + LW'(1);
            w_state_nxt = LOAD_STATE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    w_done_nxt  = (w_state_nxt == S_IDLE);
    w_blank_nxt = (w_state_nxt == S_BLANK);
    w_layer_nxt = '0;
    if (w_state_nxt == S_ACTIVE) begin
      w_layer_nxt = NUM_LAYERS'(1) << w_idx_nxt;
    end
    // High during the final hold cycle of the last layer while auto-scanning.
    w_frame_nxt = (w_state_nxt == S_ACTIVE) && (w_cnt_nxt == HOLD_LAST) &&
                  (w_idx_nxt == LAST_LAYER) && w_auto_nxt;
  end

  assign done       = r_done;
  assign blank      = r_blank;
  assign layer_out  = r_layer_out;
  assign layer_idx  = r_idx;
  assign frame_done = r_frame_done;
  assign start_err  = r_start_err;

endmodule

// File: tb/tb_layer_scanner.sv
// Scoreboard bench for layer_scanner: three builds (4 layers, 3 layers, no blanking).
module tb_layer_scanner;

  localparam int unsigned HC = 4;
  localparam int unsigned BC = 2;

  typedef struct packed {
    logic       done;
    logic       blank;
    logic [3:0] lo;
    logic [1:0] idx;
    logic       fd;
    logic       serr;
  } obs_t;

  logic clk;
  logic rst_n;

  logic       m_start, m_auto, m_stop;
  logic [1:0] m_li;
  logic       m_done, m_blank, m_fd, m_serr;
  logic [3:0] m_lo;
  logic [1:0] m_idx;

  logic       e_start, e_auto, e_stop;
  logic [1:0] e_li;
  logic       e_done, e_blank, e_fd, e_serr;
  logic [2:0] e_lo;
  logic [1:0] e_idx;

  logic       z_start, z_auto, z_stop;
  logic [1:0] z_li;
  logic       z_done, z_blank, z_fd, z_serr;
  logic [3:0] z_lo;
  logic [1:0] z_idx;

  int   n_tests;
  int   n_fail;
  obs_t q_exp[$];
  obs_t w_want;
  obs_t w_got;

  layer_scanner #(.NUM_LAYERS(4), .HOLD_CYCLES(HC), .BLANK_CYCLES(BC)) u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .auto_mode(m_auto), .stop(m_stop),
    .layer_i(m_li), .done(m_done), .blank(m_blank), .layer_out(m_lo),
    .layer_idx(m_idx), .frame_done(m_fd), .start_err(m_serr));

  layer_scanner #(.NUM_LAYERS(3), .HOLD_CYCLES(HC), .BLANK_CYCLES(BC)) u_err (
    .clk(clk), .rst_n(rst_n), .start(e_start), .auto_mode(e_auto), .stop(e_stop),
    .layer_i(e_li), .done(e_done), .blank(e_blank), .layer_out(e_lo),
    .layer_idx(e_idx), .frame_done(e_fd), .start_err(e_serr));

  layer_scanner #(.NUM_LAYERS(4), .HOLD_CYCLES(HC), .BLANK_CYCLES(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .start(z_start), .auto_mode(z_auto), .stop(z_stop),
    .layer_i(z_li), .done(z_done), .blank(z_blank), .layer_out(z_lo),
    .layer_idx(z_idx), .frame_done(z_fd), .start_err(z_serr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic d, input logic b, input logic [3:0] lo,
                              input logic [1:0] idx, input logic fd, input logic serr);
    obs_t o;
    o.done = d; o.blank = b; o.lo = lo; o.idx = idx; o.fd = fd; o.serr = serr;
    return o;
  endfunction

  function automatic obs_t obs(input int sel);
    if (sel == 1) return mk(e_done, e_blank, {1'b0, e_lo}, e_idx, e_fd, e_serr);
    if (sel == 2) return mk(z_done, z_blank, z_lo, z_idx, z_fd, z_serr);
    return mk(m_done, m_blank, m_lo, m_idx, m_fd, m_serr);
  endfunction

  // Expected trace of one layer: b blanking cycles then the hold window.
  task automatic push_layer(input int b, input logic [1:0] idx, input logic fd);
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < b; i++) q_exp.push_back(mk(1'b0, 1'b1, 4'b0000, idx, 1'b0, 1'b0));
    for (int i = 0; i < int'(HC); i++)
      q_exp.push_back(mk(1'b0, 1'b0, one << idx, idx, fd && (i == int'(HC) - 1), 1'b0));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m_start = 0; m_auto = 0; m_stop = 0; m_li = 0;
    e_start = 0; e_auto = 0; e_stop = 0; e_li = 0;
    z_start = 0; z_auto = 0; z_stop = 0; z_li = 0;
    step; step;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      w_want = mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
      w_got  = obs(s);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL reset dut=%0d got=%b want=%b", s, w_got, w_want);
      end
    end
    step;
  endtask

  task automatic test_single_layer;
    q_exp.delete();
    push_layer(BC, 2'd2, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
    m_start = 1; m_auto = 0; m_li = 2'd2;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL single k=%0d got=%b want=%b", k, w_got, w_want);
      end
    end
  endtask

  task automatic test_auto_scan;
    q_exp.delete();
    push_layer(BC, 2'd1, 1'b0);
    push_layer(BC, 2'd2, 1'b0);
    push_layer(BC, 2'd3, 1'b1);
    push_layer(BC, 2'd0, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    m_start = 1; m_auto = 1; m_li = 2'd1;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL auto_scan k=%0d got=%b want=%b", k, w_got, w_want);
      end
      m_stop = (k == 20);
    end
    m_auto = 0;
  endtask

  task automatic test_graceful_stop;
    q_exp.delete();
    push_layer(BC, 2'd3, 1'b1);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
    m_start = 1; m_auto = 1; m_li = 2'd3;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL graceful_stop k=%0d got=%b want=%b", k, w_got, w_want);
      end
      m_stop = (k == 3);
    end
    m_auto = 0;
  endtask

  task automatic test_bad_start;
    e_start = 1; e_auto = 0; e_li = 2'd3;
    step;
    e_start = 0;
    w_want = mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    w_got  = obs(1);
    n_tests++;
    if (w_got !== w_want) begin
      n_fail++;
      $display("FAIL bad_start_pulse got=%b want=%b", w_got, w_want);
    end
    step;
    w_want = mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    w_got  = obs(1);
    n_tests++;
    if (w_got !== w_want) begin
      n_fail++;
      $display("FAIL bad_start_clear got=%b want=%b", w_got, w_want);
    end
    q_exp.delete();
    push_layer(BC, 2'd2, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
    e_start = 1; e_li = 2'd2;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      e_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(1);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL good_start_3L k=%0d got=%b want=%b", k, w_got, w_want);
      end
    end
  endtask

  task automatic test_busy_start;
    q_exp.delete();
    push_layer(BC, 2'd0, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    m_start = 1; m_auto = 0; m_li = 2'd0;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0; m_auto = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL busy_start k=%0d got=%b want=%b", k, w_got, w_want);
      end
      if (k == 3) begin
        m_start = 1; m_auto = 1; m_li = 2'd3;
      end
    end
  endtask

  task automatic test_back_to_back;
    q_exp.delete();
    push_layer(BC, 2'd0, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    push_layer(BC, 2'd3, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
    m_start = 1; m_auto = 0; m_li = 2'd0;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, w_got, w_want);
      end
      if (k == 6) begin
        m_start = 1; m_li = 2'd3;
      end
    end
  endtask

  task automatic test_mid_reset;
    q_exp.delete();
    q_exp.push_back(mk(1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    m_start = 1; m_auto = 1; m_li = 2'd1;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      m_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(0);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL mid_reset k=%0d got=%b want=%b", k, w_got, w_want);
      end
      rst_n = (k == 3) ? 1'b0 : 1'b1;
    end
    m_auto = 0;
  endtask

  task automatic test_no_blank;
    q_exp.delete();
    push_layer(0, 2'd0, 1'b0);
    push_layer(0, 2'd1, 1'b0);
    push_layer(0, 2'd2, 1'b0);
    push_layer(0, 2'd3, 1'b1);
    push_layer(0, 2'd0, 1'b0);
    q_exp.push_back(mk(1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
    z_start = 1; z_auto = 1; z_li = 2'd0;
    for (int k = 0; q_exp.size() > 0; k++) begin
      step;
      z_start = 0;
      w_want = q_exp.pop_front();
      w_got  = obs(2);
      n_tests++;
      if (w_got !== w_want) begin
        n_fail++;
        $display("FAIL no_blank k=%0d got=%b want=%b", k, w_got, w_want);
      end
      z_stop = (k == 17);
    end
    z_auto = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset;
    test_single_layer;
    test_auto_scan;
    test_graceful_stop;
    test_bad_start;
    test_busy_start;
    test_back_to_back;
    test_mid_reset;
    test_no_blank;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
